// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared opcodes, instruction field positions, forward selects and slot type
package pipe_pkg;
  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 28;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;

  localparam logic [FIELD_W-1:0] OP_ADD  = 4'h0;
  localparam logic [FIELD_W-1:0] OP_SUB  = 4'h1;
  localparam logic [FIELD_W-1:0] OP_LOAD = 4'h2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic               valid;
    logic [FIELD_W-1:0] rd;
    logic               is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: '0, is_load: 1'b0};
endpackage

// File: rtl/pipe_instr_decode.sv
// rtl/pipe_instr_decode.sv - combinational decode of register usage; shared with the datapath
module pipe_instr_decode
  import pipe_pkg::*;
(
  input  logic [31:0]        instr,
  output logic [FIELD_W-1:0] rd,
  output logic [FIELD_W-1:0] rs1,
  output logic [FIELD_W-1:0] rs2,
  output logic               uses_rs1,
  output logic               uses_rs2,
  output logic               writes_rd,
  output logic               is_load
);
  logic [FIELD_W-1:0] opcode;
  logic               unused_low_bits;

  assign opcode          = instr[OPC_LSB +: FIELD_W];
  assign rd              = instr[RD_LSB  +: FIELD_W];
  assign rs1             = instr[RS1_LSB +: FIELD_W];
  assign rs2             = instr[RS2_LSB +: FIELD_W];
  assign unused_low_bits = ^instr[RS2_LSB-1:0];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_LOAD: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - issue/stall/flush control, operand forwarding and writeback for the 4-stage pipe
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REG_AW   = 4,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic              hold,
  input  logic              flush,
  output logic              if_stall,
  output logic              ex_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_dest,
  output logic [CNT_W-1:0]  stall_count
);
  if (REG_AW > FIELD_W || NUM_REGS > (1 << REG_AW)) begin : g_cfg_check
    $error("pipeline_hazard_ctrl: register index does not fit the instruction fields");
  end

  slot_t              slot_ex, slot_wb;
  logic [FIELD_W-1:0] rd, rs1, rs2;
  logic               uses_rs1, uses_rs2, writes_rd, is_load;
  logic               haz_a, haz_b, hazard, issue;
  logic [1:0]         sel_a, sel_b;

  pipe_instr_decode u_decode (
    .instr     (id_instr),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_load   (is_load)
  );

  // Returns {hazard, select}; the EX slot is younger, so it shadows a WB match on the same register.
  function automatic logic [2:0] resolve(input logic used, input logic [FIELD_W-1:0] rs,
                                         input slot_t ex, input slot_t wb);
    logic       hit_ex, hit_wb;
    logic [2:0] r;
    hit_ex = used && ex.valid && (rs == ex.rd);
    hit_wb = used && wb.valid && (rs == wb.rd);
    r = {1'b0, FWD_RF};
    if (FWD_EN == 0)  r = {hit_ex | hit_wb, FWD_RF};
    else if (hit_ex)  r = ex.is_load ? {1'b1, FWD_RF} : {1'b0, FWD_EX};
    else if (hit_wb)  r = {1'b0, FWD_MEM};
    return r;
  endfunction

  assign {haz_a, sel_a} = resolve(uses_rs1, rs1, slot_ex, slot_wb);
  assign {haz_b, sel_b} = resolve(uses_rs2, rs2, slot_ex, slot_wb);

  assign hazard    = id_valid && !flush && (haz_a || haz_b);
  assign issue     = id_valid && !flush && !hazard && !hold;
  assign if_stall  = hold || hazard;
  assign ex_bubble = !id_valid || flush || hazard;
  assign fwd_a_sel = issue ? sel_a : FWD_RF;
  assign fwd_b_sel = issue ? sel_b : FWD_RF;
  assign wb_en     = slot_wb.valid && !hold;
  assign wb_dest   = slot_wb.valid ? REG_AW'(slot_wb.rd) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_ex     <= SLOT_EMPTY;
      slot_wb     <= SLOT_EMPTY;
      stall_count <= '0;
    end else if (!hold) begin
      slot_wb <= slot_ex;
      slot_ex <= issue ? '{valid: writes_rd, rd: rd, is_load: is_load} : SLOT_EMPTY;
      if (hazard && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench over three configurations sharing one stimulus stream
module tb_pipeline_hazard_ctrl;
  typedef struct packed {
    logic        if_stall;
    logic        ex_bubble;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [15:0] cnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset, id_valid, hold, flush;
  logic [31:0] id_instr;

  logic        if_stall0, if_stall1, if_stall2, ex_bubble0, ex_bubble1, ex_bubble2;
  logic [1:0]  fa0, fa1, fa2, fb0, fb1, fb2;
  logic        wb_en0, wb_en1, wb_en2;
  logic [3:0]  wd0, wd1, wd2;
  logic [15:0] cnt0, cnt1;
  logic [3:0]  cnt2;
  obs_t        obs0, obs1, obs2;

  int checks = 0;
  int errors = 0;

  obs_t sbq[$];

  // reference model state, one entry per configuration
  int          fwd_cfg[3] = '{1, 0, 1};
  int          cnt_max[3] = '{65535, 65535, 15};
  logic        m_ex_v[3], m_ex_ld[3], m_wb_v[3];
  logic [3:0]  m_ex_rd[3], m_wb_rd[3];
  int          m_cnt[3];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.NUM_REGS(16), .REG_AW(4), .FWD_EN(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .hold(hold), .flush(flush),
    .if_stall(if_stall0), .ex_bubble(ex_bubble0), .fwd_a_sel(fa0), .fwd_b_sel(fb0),
    .wb_en(wb_en0), .wb_dest(wd0), .stall_count(cnt0));
  pipeline_hazard_ctrl #(.NUM_REGS(16), .REG_AW(4), .FWD_EN(0), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .hold(hold), .flush(flush),
    .if_stall(if_stall1), .ex_bubble(ex_bubble1), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
    .wb_en(wb_en1), .wb_dest(wd1), .stall_count(cnt1));
  pipeline_hazard_ctrl #(.NUM_REGS(16), .REG_AW(4), .FWD_EN(1), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr), .hold(hold), .flush(flush),
    .if_stall(if_stall2), .ex_bubble(ex_bubble2), .fwd_a_sel(fa2), .fwd_b_sel(fb2),
    .wb_en(wb_en2), .wb_dest(wd2), .stall_count(cnt2));

  assign obs0 = {if_stall0, ex_bubble0, fa0, fb0, wb_en0, wd0, cnt0};
  assign obs1 = {if_stall1, ex_bubble1, fa1, fb1, wb_en1, wd1, cnt1};
  assign obs2 = {if_stall2, ex_bubble2, fa2, fb2, wb_en2, wd2, 12'h000, cnt2};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 16'h0000};
  endfunction

  // Operand source per the forwarding rules: returns {stall_needed, select}
  function automatic logic [2:0] src_eval(input int c, input logic used, input logic [3:0] r);
    if (!used) return 3'b000;
    if (m_ex_v[c] && m_ex_rd[c] == r) begin
      if (fwd_cfg[c] == 0 || m_ex_ld[c]) return 3'b100;
      return 3'b001;
    end
    if (m_wb_v[c] && m_wb_rd[c] == r) return (fwd_cfg[c] == 0) ? 3'b100 : 3'b010;
    return 3'b000;
  endfunction

  task automatic step(input logic rst, input logic v, input logic [31:0] instr,
                      input logic hd, input logic fl);
    logic [3:0] op;
    logic       writer, use2, ld, hz, iss;
    logic [2:0] s1, s2;
    obs_t       e, got;
    @(negedge clk);
    reset = rst; id_valid = v; id_instr = instr; hold = hd; flush = fl;
    op     = instr[31:28];
    writer = (op == 4'h0) || (op == 4'h1) || (op == 4'h2);
    use2   = (op == 4'h0) || (op == 4'h1);
    ld     = (op == 4'h2);
    for (int c = 0; c < 3; c++) begin
      if (!rst) begin
        m_ex_v[c] = 0; m_ex_rd[c] = 0; m_ex_ld[c] = 0;
        m_wb_v[c] = 0; m_wb_rd[c] = 0; m_cnt[c] = 0;
      end
      s1  = src_eval(c, writer, instr[23:20]);
      s2  = src_eval(c, use2, instr[19:16]);
      hz  = v && !fl && (s1[2] || s2[2]);
      iss = v && !fl && !hz && !hd;
      e.if_stall  = hd || hz;
      e.ex_bubble = !v || fl || hz;
      e.fa        = iss ? s1[1:0] : 2'b00;
      e.fb        = iss ? s2[1:0] : 2'b00;
      e.wb_en     = m_wb_v[c] && !hd;
      e.wb_dest   = m_wb_v[c] ? m_wb_rd[c] : 4'h0;
      e.cnt       = 16'(m_cnt[c]);
      sbq.push_back(e);
      if (rst && !hd) begin
        m_wb_v[c]  = m_ex_v[c];
        m_wb_rd[c] = m_ex_rd[c];
        m_ex_v[c]  = iss && writer;
        m_ex_rd[c] = iss ? instr[27:24] : 4'h0;
        m_ex_ld[c] = iss && ld;
        if (hz && m_cnt[c] < cnt_max[c]) m_cnt[c]++;
      end
    end
    #2;
    for (int c = 0; c < 3; c++) begin
      e   = sbq.pop_front();
      got = (c == 0) ? obs0 : (c == 1) ? obs1 : obs2;
      check_eq($sformatf("c%0d_if_stall", c),  got.if_stall,  e.if_stall);
      check_eq($sformatf("c%0d_ex_bubble", c), got.ex_bubble, e.ex_bubble);
      check_eq($sformatf("c%0d_fwd_a", c),     got.fa,        e.fa);
      check_eq($sformatf("c%0d_fwd_b", c),     got.fb,        e.fb);
      check_eq($sformatf("c%0d_wb_en", c),     got.wb_en,     e.wb_en);
      check_eq($sformatf("c%0d_wb_dest", c),   got.wb_dest,   e.wb_dest);
      check_eq($sformatf("c%0d_stall_cnt", c), got.cnt,       e.cnt);
    end
  endtask

  localparam logic [31:0] NOP = 32'hF000_0000;

  initial begin
    reset = 1'b0; id_valid = 1'b0; id_instr = NOP; hold = 1'b0; flush = 1'b0;

    // reset mid-stream with ADD r3 in the EX slot
    step(0, 0, NOP, 0, 0);
    check_eq("rst_ex_bubble", ex_bubble0, 1'b1);
    step(1, 1, ins(4'h0, 4'd3, 4'd1, 4'd2), 0, 0);
    step(0, 1, NOP, 0, 0);
    check_eq("rst_wb_en", wb_en0, 1'b0);
    check_eq("rst_cnt", cnt0, 16'd0);
    step(1, 0, NOP, 0, 0);
    check_eq("rst_no_write_r3", wb_en0, 1'b0);
    step(1, 0, NOP, 0, 0);

    // ADD r1 then SUB r4,r1,r5: EX forward, no stall
    step(0, 0, NOP, 0, 0);
    step(1, 1, ins(4'h0, 4'd1, 4'd2, 4'd3), 0, 0);
    step(1, 1, ins(4'h1, 4'd4, 4'd1, 4'd5), 0, 0);
    check_eq("fwd_ex_a", fa0, 2'b01);
    check_eq("fwd_ex_b", fb0, 2'b00);
    check_eq("fwd_ex_nostall", if_stall0, 1'b0);
    step(1, 0, NOP, 0, 0);

    // load-use: one stall, then WB forward on both operands
    step(0, 0, NOP, 0, 0);
    step(1, 1, ins(4'h2, 4'd6, 4'd7, 4'd0), 0, 0);
    step(1, 1, ins(4'h0, 4'd8, 4'd6, 4'd6), 0, 0);
    check_eq("lu_if_stall", if_stall0, 1'b1);
    check_eq("lu_ex_bubble", ex_bubble0, 1'b1);
    step(1, 1, ins(4'h0, 4'd8, 4'd6, 4'd6), 0, 0);
    check_eq("lu_fwd_a", fa0, 2'b10);
    check_eq("lu_fwd_b", fb0, 2'b10);
    check_eq("lu_cnt", cnt0, 16'd1);

    // no forwarding: two stalls, issue after the writeback cycle
    step(0, 0, NOP, 0, 0);
    step(1, 1, ins(4'h0, 4'd1, 4'd2, 4'd3), 0, 0);
    step(1, 1, ins(4'h0, 4'd2, 4'd1, 4'd1), 0, 0);
    check_eq("nofwd_stall1", if_stall1, 1'b1);
    step(1, 1, ins(4'h0, 4'd2, 4'd1, 4'd1), 0, 0);
    check_eq("nofwd_wb_en", wb_en1, 1'b1);
    check_eq("nofwd_wb_dest", wd1, 4'd1);
    step(1, 1, ins(4'h0, 4'd2, 4'd1, 4'd1), 0, 0);
    check_eq("nofwd_issue", if_stall1, 1'b0);
    check_eq("nofwd_sels", {fa1, fb1}, 4'b0000);
    check_eq("nofwd_cnt", cnt1, 16'd2);

    // hold for three cycles over a pending load-use hazard
    step(0, 0, NOP, 0, 0);
    step(1, 1, ins(4'h2, 4'd6, 4'd7, 4'd0), 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, ins(4'h0, 4'd8, 4'd6, 4'd6), 1, 0);
      check_eq("hold_wb_en", wb_en0, 1'b0);
    end
    check_eq("hold_cnt", cnt0, 16'd0);
    step(1, 1, ins(4'h0, 4'd8, 4'd6, 4'd6), 0, 0);
    step(1, 1, ins(4'h0, 4'd8, 4'd6, 4'd6), 0, 0);
    check_eq("hold_resume_fwd", fa0, 2'b10);
    check_eq("hold_resume_cnt", cnt0, 16'd1);

    // flush on a hazard cycle: older slots still drain
    step(0, 0, NOP, 0, 0);
    step(1, 1, ins(4'h0, 4'd1, 4'd2, 4'd3), 0, 0);
    step(1, 1, ins(4'h2, 4'd6, 4'd7, 4'd0), 0, 0);
    step(1, 1, ins(4'h0, 4'd8, 4'd6, 4'd6), 0, 1);
    check_eq("flush_bubble", ex_bubble0, 1'b1);
    check_eq("flush_wb_en", wb_en0, 1'b1);
    check_eq("flush_cnt", cnt0, 16'd0);
    step(1, 0, NOP, 0, 0);
    check_eq("flush_drain_dest", wd0, 4'd6);

    // same rd in both slots, and rs1 == rs2 on the youngest
    step(0, 0, NOP, 0, 0);
    step(1, 1, ins(4'h0, 4'd5, 4'd1, 4'd1), 0, 0);
    step(1, 1, ins(4'h0, 4'd5, 4'd2, 4'd2), 0, 0);
    step(1, 1, ins(4'h1, 4'd9, 4'd5, 4'd5), 0, 0);
    check_eq("young_fwd_a", fa0, 2'b01);
    check_eq("young_fwd_b", fb0, 2'b01);

    // saturation: 20 load-use stalls
    step(0, 0, NOP, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, ins(4'h2, 4'd6, 4'd7, 4'd0), 0, 0);
      step(1, 1, ins(4'h0, 4'd8, 4'd6, 4'd6), 0, 0);
      step(1, 1, ins(4'h0, 4'd8, 4'd6, 4'd6), 0, 0);
    end
    check_eq("sat_cnt4", cnt2, 4'd15);
    check_eq("sat_cnt16", cnt0, 16'd20);

    // random mix against the model
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 3));
      step(($urandom % 50) != 0, ($urandom % 4) != 0,
           ins(op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))),
           ($urandom % 8) == 0, ($urandom % 8) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
